// File: rtl/gpu_pkg.sv
// Shared types and defaults for the 2D shapes GPU drawing engines.
package gpu_pkg;

  localparam int unsigned CoordWDefault = 8;
  localparam int unsigned ColorWDefault = 24;

  // Command lifecycle of a drawing engine.
  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StDraw,
    StFinish
  } raster_state_e;

  // Rectangle command at the default widths.
  typedef struct packed {
    logic [CoordWDefault-1:0] x0;
    logic [CoordWDefault-1:0] y0;
    logic [CoordWDefault-1:0] x1;
    logic [CoordWDefault-1:0] y1;
    logic                     fill_enable;
    logic [ColorWDefault-1:0] color;
  } rect_cmd_t;

endpackage

// File: rtl/rect_bounds.sv
// Corner normalisation and screen clipping for a rectangle command.
// Clipping and the off-screen flag exist only when RECT_RASTER_CLIP_EN is defined.
module rect_bounds
  import gpu_pkg::*;
#(
  parameter int unsigned COORD_W  = CoordWDefault,
  parameter int unsigned SCREEN_W = 256,
  parameter int unsigned SCREEN_H = 256
) (
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] y0,
  input  logic [COORD_W-1:0] x1,
  input  logic [COORD_W-1:0] y1,
  output logic [COORD_W-1:0] xmin,
  output logic [COORD_W-1:0] xmax,
  output logic [COORD_W-1:0] ymin,
  output logic [COORD_W-1:0] ymax,
  output logic [COORD_W-1:0] cxl,
  output logic [COORD_W-1:0] cxh,
  output logic [COORD_W-1:0] cyl,
  output logic [COORD_W-1:0] cyh,
  output logic               empty
);

`ifdef RECT_RASTER_CLIP_EN
  localparam logic [COORD_W-1:0] XLim = COORD_W'(SCREEN_W - 1);
  localparam logic [COORD_W-1:0] YLim = COORD_W'(SCREEN_H - 1);
`endif

  // Order the corners, then clamp the far edges to the screen.
  always_comb begin
    xmin = (x0 < x1) ? x0 : x1;
    xmax = (x0 < x1) ? x1 : x0;
    ymin = (y0 < y1) ? y0 : y1;
    ymax = (y0 < y1) ? y1 : y0;
    cxl  = xmin;
    cyl  = ymin;
`ifdef RECT_RASTER_CLIP_EN
    cxh   = (xmax > XLim) ? XLim : xmax;
    cyh   = (ymax > YLim) ? YLim : ymax;
    empty = (xmin > XLim) || (ymin > YLim);
`else
    cxh   = xmax;
    cyh   = ymax;
    empty = 1'b0;
`endif
  end

endmodule

// File: rtl/rect_raster.sv
// Rectangle rasteriser: accepts one command, normalises and (with RECT_RASTER_CLIP_EN)
// clips it, then streams filled or outline pixels on a back-pressured pixel port.
module rect_raster
  import gpu_pkg::*;
#(
  parameter int unsigned COORD_W  = CoordWDefault,
  parameter int unsigned COLOR_W  = ColorWDefault,
  parameter int unsigned SCREEN_W = 256,
  parameter int unsigned SCREEN_H = 256
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] y0,
  input  logic [COORD_W-1:0] x1,
  input  logic [COORD_W-1:0] y1,
  input  logic               fill_enable,
  input  logic [COLOR_W-1:0] color,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic [COORD_W-1:0] px,
  output logic [COORD_W-1:0] py,
  output logic [COLOR_W-1:0] pix_color,
  output logic               busy,
  output logic               done
);

  raster_state_e state_q, state_d;

  logic [COORD_W-1:0] x0_q, y0_q, x1_q, y1_q;
  logic               fill_q;
  logic [COLOR_W-1:0] color_q;

  logic [COORD_W-1:0] xmin_q, xmax_q, ymin_q, ymax_q, cxl_q, cxh_q, cyh_q;
  logic [COORD_W-1:0] b_xmin, b_xmax, b_ymin, b_ymax, b_cxl, b_cxh, b_cyl, b_cyh;
  logic               b_empty;

  // px/py double as the scan position; pv_q low in DRAW marks an idle interior row.
  logic [COORD_W-1:0] px_q, px_d, py_q, py_d;
  logic               pv_q, pv_d;

  logic               cmd_accept;
  logic [COORD_W-1:0] y_next, x_step;
  logic               left_vis, right_vis, row_is_border, next_is_border, row_more;

  assign cmd_accept = (state_q == StIdle) && cmd_valid;

  rect_bounds #(
    .COORD_W (COORD_W),
    .SCREEN_W(SCREEN_W),
    .SCREEN_H(SCREEN_H)
  ) u_bounds (
    .x0   (x0_q),
    .y0   (y0_q),
    .x1   (x1_q),
    .y1   (y1_q),
    .xmin (b_xmin),
    .xmax (b_xmax),
    .ymin (b_ymin),
    .ymax (b_ymax),
    .cxl  (b_cxl),
    .cxh  (b_cxh),
    .cyl  (b_cyl),
    .cyh  (b_cyh),
    .empty(b_empty)
  );

  // Row classification: border rows emit every clipped x, interior rows only visible edges.
  always_comb begin
    y_next         = py_q + COORD_W'(1);
    left_vis       = (cxl_q == xmin_q);
    right_vis      = (cxh_q == xmax_q);
    row_is_border  = fill_q || (py_q == ymin_q) || (py_q == ymax_q);
    next_is_border = fill_q || (y_next == ymin_q) || (y_next == ymax_q);
    row_more       = row_is_border ? (px_q < cxh_q) : (right_vis && (px_q < cxh_q));
    x_step         = row_is_border ? (px_q + COORD_W'(1)) : cxh_q;
  end

  // Next-state and scan-position update.
  always_comb begin
    state_d = state_q;
    px_d    = px_q;
    py_d    = py_q;
    pv_d    = pv_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) state_d = StSetup;
      end
      StSetup: begin
        if (b_empty) begin
          state_d = StFinish;
        end else begin
          px_d    = b_cxl;
          py_d    = b_cyl;
          pv_d    = 1'b1;
          state_d = StDraw;
        end
      end
      StDraw: begin
        // Advance only on a handshake or while passing over an idle row.
        if (!pv_q || pix_ready) begin
          if (pv_q && row_more) begin
            px_d = x_step;
          end else if (py_q == cyh_q) begin
            pv_d    = 1'b0;
            state_d = StFinish;
          end else begin
            py_d = y_next;
            if (next_is_border || left_vis) begin
              px_d = cxl_q;
              pv_d = 1'b1;
            end else if (right_vis) begin
              px_d = cxh_q;
              pv_d = 1'b1;
            end else begin
              px_d = cxl_q;
              pv_d = 1'b0;
            end
          end
        end
      end
      StFinish: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State, command capture and bounds capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      px_q    <= '0;
      py_q    <= '0;
      pv_q    <= 1'b0;
      x0_q    <= '0;
      y0_q    <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      fill_q  <= 1'b0;
      color_q <= '0;
      xmin_q  <= '0;
      xmax_q  <= '0;
      ymin_q  <= '0;
      ymax_q  <= '0;
      cxl_q   <= '0;
      cxh_q   <= '0;
      cyh_q   <= '0;
    end else begin
      state_q <= state_d;
      px_q    <= px_d;
      py_q    <= py_d;
      pv_q    <= pv_d;
      if (cmd_accept) begin
        x0_q    <= x0;
        y0_q    <= y0;
        x1_q    <= x1;
        y1_q    <= y1;
        fill_q  <= fill_enable;
        color_q <= color;
      end
      if (state_q == StSetup) begin
        xmin_q <= b_xmin;
        xmax_q <= b_xmax;
        ymin_q <= b_ymin;
        ymax_q <= b_ymax;
        cxl_q  <= b_cxl;
        cxh_q  <= b_cxh;
        cyh_q  <= b_cyh;
      end
    end
  end

  assign cmd_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StFinish);
  assign pix_valid = pv_q;
  assign px        = px_q;
  assign py        = py_q;
  assign pix_color = color_q;

endmodule

// File: tb/tb_rect_raster.sv
// Self-checking bench for rect_raster: a set-based pixel model, a per-cycle compare
// process, and directed commands. Clipping cases follow RECT_RASTER_CLIP_EN.
module tb_rect_raster;

  localparam int CW = 8;
  localparam int KW = 24;
  localparam int SW = 16;
  localparam int SH = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          fill_enable = 1'b0;
  logic          pix_ready = 1'b1;
  logic [CW-1:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0;
  logic [KW-1:0] color = '0;
  logic          cmd_ready, pix_valid, busy, done;
  logic [CW-1:0] px, py;
  logic [KW-1:0] pix_color;

  always #5 clk = ~clk;

  rect_raster #(
    .COORD_W (CW),
    .COLOR_W (KW),
    .SCREEN_W(SW),
    .SCREEN_H(SH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .x0         (x0),
    .y0         (y0),
    .x1         (x1),
    .y1         (y1),
    .fill_enable(fill_enable),
    .color      (color),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .px         (px),
    .py         (py),
    .pix_color  (pix_color),
    .busy       (busy),
    .done       (done)
  );

  typedef struct {
    int x;
    int y;
  } pt_t;

  pt_t           exp_q[$];
  logic [KW-1:0] exp_color;
  int            n_cmp = 0;
  int            n_err = 0;
  int            cyc = 0;
  int            accept_cyc = 0;
  int            last_hs = 0;
  int            hs_count = 0;
  int            done_cnt = 0;
  bit            first_pending = 0;
  bit            got_pix = 0;
  bit            stall_prev = 0;
  logic [CW-1:0] hold_px, hold_py;
  logic [KW-1:0] hold_col;

  function automatic void check(string name, longint act, longint req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // Expected pixels: every point of the normalised box that is on screen and either
  // filled or on the box border, in raster order.
  task automatic model_push(input int ax0, input int ay0, input int ax1, input int ay1,
                            input bit f);
    int xl, xh, yl, yh;
    bit vis;
    xl = (ax0 < ax1) ? ax0 : ax1;
    xh = (ax0 < ax1) ? ax1 : ax0;
    yl = (ay0 < ay1) ? ay0 : ay1;
    yh = (ay0 < ay1) ? ay1 : ay0;
    for (int y = yl; y <= yh; y++) begin
      for (int x = xl; x <= xh; x++) begin
`ifdef RECT_RASTER_CLIP_EN
        vis = (x <= SW - 1) && (y <= SH - 1);
`else
        vis = 1'b1;
`endif
        if (vis && (f || x == xl || x == xh || y == yl || y == yh)) begin
          exp_q.push_back('{x: x, y: y});
        end
      end
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Per-cycle compare against the model queue.
  initial begin
    pt_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_prev    = 0;
        first_pending = 0;
      end else begin
        check("ready_vs_busy", cmd_ready, !busy);
        if (cmd_valid && cmd_ready) begin
          accept_cyc    = cyc;
          first_pending = 1;
          got_pix       = 0;
          hs_count      = 0;
        end
        if (stall_prev) begin
          check("stall_valid", pix_valid, 1);
          check("stall_px", px, hold_px);
          check("stall_py", py, hold_py);
          check("stall_color", pix_color, hold_col);
        end
        if (pix_valid) begin
          if (first_pending) begin
            check("first_latency", cyc - accept_cyc, 2);
            first_pending = 0;
          end
          if (pix_ready) begin
            check("pixel_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
              e = exp_q.pop_front();
              check("px", px, e.x);
              check("py", py, e.y);
              check("pix_color", pix_color, exp_color);
            end
            hs_count++;
            got_pix = 1;
            last_hs = cyc;
          end
        end
        if (done) begin
          check("done_queue_empty", exp_q.size(), 0);
          if (got_pix) check("done_after_last", cyc - last_hs, 1);
          else check("done_empty_latency", cyc - accept_cyc, 2);
          done_cnt++;
          first_pending = 0;
        end
        stall_prev = pix_valid && !pix_ready;
        hold_px    = px;
        hold_py    = py;
        hold_col   = pix_color;
      end
    end
  end

  task automatic check_reset_values();
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_pix_valid", pix_valid, 0);
    check("rst_px", px, 0);
    check("rst_py", py, 0);
    check("rst_pix_color", pix_color, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
  endtask

  task automatic send_cmd(input int ax0, input int ay0, input int ax1, input int ay1,
                          input bit f, input int c);
    @(posedge clk);
    #1;
    x0          = CW'(ax0);
    y0          = CW'(ay0);
    x1          = CW'(ax1);
    y1          = CW'(ay1);
    fill_enable = f;
    color       = KW'(c);
    cmd_valid   = 1'b1;
    pix_ready   = 1'b1;
    @(posedge clk);
    #1;
    // Scramble inputs after acceptance; the engine must ignore them.
    cmd_valid   = 1'b0;
    x0          = 8'hA5;
    y0          = 8'h5A;
    x1          = 8'h00;
    y1          = 8'hFF;
    fill_enable = ~f;
    color       = ~KW'(c);
  endtask

  task automatic run_cmd(input string name, input int ax0, input int ay0, input int ax1,
                         input int ay1, input bit f, input int c, input bit rnd,
                         input int exp_n);
    int d0;
    bit seen;
    model_push(ax0, ay0, ax1, ay1, f);
    exp_color = KW'(c);
    check({name, "_model_count"}, exp_q.size(), exp_n);
    d0   = done_cnt;
    seen = 0;
    send_cmd(ax0, ay0, ax1, ay1, f, c);
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (done_cnt != d0) begin
        seen = 1;
        break;
      end
      @(posedge clk);
      #1;
      pix_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    check({name, "_done_seen"}, seen, 1);
    check({name, "_pixel_count"}, hs_count, exp_n);
    exp_q.delete();
  endtask

  initial begin
    int d0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_values();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Pin the model's raster order with hand-computed corners.
    model_push(2, 3, 4, 5, 1);
    check("model_first_x", exp_q[0].x, 2);
    check("model_first_y", exp_q[0].y, 3);
    check("model_last_x", exp_q[exp_q.size()-1].x, 4);
    check("model_last_y", exp_q[exp_q.size()-1].y, 5);
    check("model_row4_x", exp_q[3].x, 2);
    exp_q.delete();
    model_push(5, 5, 1, 1, 0);
    check("model_outline_mid_x0", exp_q[5].x, 1);
    check("model_outline_mid_x1", exp_q[6].x, 5);
    exp_q.delete();

    run_cmd("fill_3x3", 2, 3, 4, 5, 1, 24'h12_34_56, 0, 9);
    run_cmd("outline_swapped", 5, 5, 1, 1, 0, 24'hFF_00_00, 0, 16);
    run_cmd("one_by_one", 7, 7, 7, 7, 0, 24'h00_FF_00, 0, 1);
    run_cmd("one_by_one_fill", 7, 7, 7, 7, 1, 24'h00_FF_01, 0, 1);
    run_cmd("width1_outline", 3, 4, 3, 9, 0, 24'h00_00_FF, 0, 6);
    run_cmd("height1_outline", 8, 6, 2, 6, 0, 24'hAB_CD_EF, 0, 7);
    run_cmd("two_row_outline", 0, 0, 3, 1, 0, 24'h11_11_11, 0, 8);
`ifdef RECT_RASTER_CLIP_EN
    run_cmd("clip_outline", 12, 12, 20, 20, 0, 24'h22_22_22, 0, 7);
    run_cmd("offscreen", 20, 0, 30, 5, 1, 24'h33_33_33, 0, 0);
    run_cmd("clip_fill", 14, 13, 40, 2, 1, 24'h44_44_44, 0, 24);
`else
    run_cmd("noclip_outline", 12, 12, 20, 20, 0, 24'h22_22_22, 0, 32);
    run_cmd("noclip_fill", 20, 0, 30, 5, 1, 24'h33_33_33, 0, 66);
`endif
    run_cmd("backpressure_fill", 3, 3, 0, 0, 1, 24'h55_AA_55, 1, 16);
    run_cmd("backpressure_outline", 0, 0, 5, 4, 0, 24'h66_77_88, 1, 18);

    // Reset in the middle of a fill after the third pixel.
    d0 = done_cnt;
    model_push(0, 0, 5, 5, 1);
    exp_color = 24'h99_99_99;
    send_cmd(0, 0, 5, 5, 1, 24'h99_99_99);
    for (int k = 0; k < 50 && hs_count < 3; k++) @(negedge clk);
    check("rst_mid_reached_3", hs_count, 3);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check_reset_values();
    repeat (10) @(negedge clk);
    check("rst_mid_no_done", done_cnt, d0);
    check("rst_mid_idle_busy", busy, 0);

    run_cmd("after_reset_fill", 1, 1, 2, 2, 1, 24'h0F_0F_0F, 0, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
